mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multicycle MIPS main control unit; sequences the shared datapath: PC, memory, IR, register file, sign/zero extender, ALU.
- Moore FSM driven by IR opcode/funct.
- Issues one memory access at a time and waits on a ready handshake.
- Selects sign- vs zero-extension of the 16-bit immediate for each instruction.

Parameters:
- OPW, 6, opcode and funct field width.
- SW, 4, state register width; must be ≥ 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_en  out  1  PC load enable.
- pc_src  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
- iord  out  1  memory address source: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_dst  out  1  write register: 0 rt, 1 rd.
- mem_to_reg  out  1  writeback source: 0 ALUOut, 1 MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A: 0 PC, 1 register A.
- alu_src_b  out  2  ALU B: 00 register B, 01 const 4, 10 ext(imm), 11 ext(imm)<<2.
- alu_ctrl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- ext_sel  out  1  1 sign-extend, 0 zero-extend.
- illegal  out  1  undefined opcode seen in DECODE.
- state_o  out  SW  current state, debug only.

Behaviour:
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, j 000010.
- R-type funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct gives add.
- Reset: state=FETCH asynchronously. While rst_n=0 every output is 0, including state_o. After release, FETCH outputs appear.
- Outputs are a pure function of the registered state (plus opcode/zero/mem_ready where noted). Any signal not listed for a state is 0. ext_sel defaults to 1.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00.
  - If mem_ready=1: ir_write=1, pc_en=1, next DECODE.
  - Else: remain in FETCH, ir_write=0, pc_en=0.
- DECODE: alu_src_a=0, alu_src_b=11, add, ext_sel=1 (precompute branch target). Next state:
  - lw/sw → MEMADR
  - R → EXEC
  - beq/bne → BRANCH
  - addi/andi/ori → IEXEC
  - j → JUMP
  - otherwise illegal=1 for this cycle, next FETCH
- MEMADR: alu_src_a=1, alu_src_b=10, add, ext_sel=1. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: iord=1, mem_read=1. Wait for mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEMWR: iord=1, mem_write=1. Wait for mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct. Next ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01. pc_en=zero for beq, pc_en=~zero for bne. Next FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10.
  - addi: add, ext_sel=1.
  - andi: and, ext_sel=0.
  - ori: or, ext_sel=0.
  - Next IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- JUMP: pc_src=10, pc_en=1. Next FETCH.
- Latency with zero wait states: lw 5, sw 4, R 4, addi/andi/ori 4, beq/bne 3, j 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Handshake: requests hold steady until mem_ready. mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- opcode must stay stable from DECODE to the end of the instruction (IR is loaded only in FETCH).
- Unused state encodings recover to FETCH on the next edge.
- Reset mid-instruction: no further strobes issue; any partial access is abandoned.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - opcode and funct constants
  - state encodings: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IEXEC, IWB, JUMP
  - alu_ctrl codes
  - alu_src_b and pc_src select codes
- One sub-module, alu_decoder: combinational; takes a 2-bit alu_op (add / sub / funct / immediate-logic), funct and opcode, and produces alu_ctrl.

Test Plan:
- Reset then lw (opcode 100011), mem_ready=1 always → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 with mem_to_reg=1 in cycle 5; pc_en=1 only in cycle 1.
- sw with mem_ready=0 for 2 cycles in MEMWR → mem_write=1 and iord=1 held 3 cycles, then FETCH; no reg_write.
- beq with zero=1 → pc_en=1, pc_src=01 in BRANCH. Same with zero=0 → pc_en=0. bne with zero=0 → pc_en=1.
- andi → ext_sel=0, alu_ctrl=000, alu_src_b=10 in IEXEC. addi → ext_sel=1, alu_ctrl=010. R-type funct 101010 → alu_ctrl=111, then reg_dst=1 write.
- Opcode 111111 → illegal=1 for exactly one DECODE cycle, next state FETCH, no reg_write or mem_write.
- rst_n low during MEMRD wait → all outputs 0 immediately; after release, state_o=FETCH and mem_read=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main control unit:
// instruction field codes, state encodings, ALU codes and mux select codes.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_IMM   = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       ext_sel;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU operation decoder: maps the FSM's coarse alu_op plus the IR funct/opcode
// fields onto the 3-bit ALU control code.
module alu_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  alu_op_t          alu_op,
    input  logic [OPW-1:0]   funct,
    input  logic [OPW-1:0]   opcode,
    output logic [2:0]       alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            // addi falls through to add; only the logical immediates differ
            ALUOP_IMM: begin
                case (opcode)
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch, decode, execute,
// memory and writeback over a shared datapath with a ready-handshaked memory.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int SW  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] funct,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           pc_en,
    output logic [1:0]     pc_src,
    output logic           iord,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [2:0]     alu_ctrl,
    output logic           ext_sel,
    output logic           illegal,
    output logic [SW-1:0]  state_o
);

    state_t  state, state_next;
    alu_op_t alu_op;
    logic [2:0] alu_ctrl_dec;
    ctrl_t   ctrl, ctrl_out;

    alu_decoder #(.OPW(OPW)) u_alu_decoder (
        .alu_op   (alu_op),
        .funct    (funct),
        .opcode   (opcode),
        .alu_ctrl (alu_ctrl_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        case (state)
            BRANCH:  alu_op = ALUOP_SUB;
            EXEC:    alu_op = ALUOP_FUNCT;
            IEXEC:   alu_op = ALUOP_IMM;
            default: alu_op = ALUOP_ADD;
        endcase
    end

    always_comb begin
        state_next   = FETCH;
        ctrl         = '0;
        ctrl.ext_sel = 1'b1;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_ctrl  = alu_ctrl_dec;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
                state_next     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_ctrl  = alu_ctrl_dec;
                case (opcode)
                    OP_LW, OP_SW:             state_next = MEMADR;
                    OP_RTYPE:                 state_next = EXEC;
                    OP_BEQ, OP_BNE:           state_next = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_next = IEXEC;
                    OP_J:                     state_next = JUMP;
                    default: begin
                        ctrl.illegal = 1'b1;
                        state_next   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ctrl  = alu_ctrl_dec;
                state_next     = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
                state_next    = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                state_next     = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_ctrl  = alu_ctrl_dec;
                state_next     = ALUWB;
            end
            ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_ctrl  = alu_ctrl_dec;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.pc_en     = (opcode == OP_BNE) ? ~zero : zero;
            end
            IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ctrl  = alu_ctrl_dec;
                ctrl.ext_sel   = (opcode == OP_ADDI);
                state_next     = IWB;
            end
            IWB:  ctrl.reg_write = 1'b1;
            JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_en  = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // Reset forces every output low even though the register already holds FETCH
    assign ctrl_out = rst_n ? ctrl : '0;
    assign state_o  = rst_n ? SW'(state) : '0;

    assign pc_en      = ctrl_out.pc_en;
    assign pc_src     = ctrl_out.pc_src;
    assign iord       = ctrl_out.iord;
    assign mem_read   = ctrl_out.mem_read;
    assign mem_write  = ctrl_out.mem_write;
    assign ir_write   = ctrl_out.ir_write;
    assign reg_dst    = ctrl_out.reg_dst;
    assign mem_to_reg = ctrl_out.mem_to_reg;
    assign reg_write  = ctrl_out.reg_write;
    assign alu_src_a  = ctrl_out.alu_src_a;
    assign alu_src_b  = ctrl_out.alu_src_b;
    assign alu_ctrl   = ctrl_out.alu_ctrl;
    assign ext_sel    = ctrl_out.ext_sel;
    assign illegal    = ctrl_out.illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: builds each instruction's expected cycle-by-cycle
// control trace from the instruction class and compares it with the DUT.
module tb_mc_control_fsm;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7,
                           S_BRANCH = 4'd8, S_IEXEC = 4'd9, S_IWB = 4'd10, S_JUMP = 4'd11;

    localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW_OP = 6'b101011, BEQ = 6'b000100,
                           BNE = 6'b000101, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101,
                           J_OP = 6'b000010;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       ext_sel, illegal;
    } exp_t;

    typedef struct {
        exp_t e;
        logic rdy;
        logic z;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, ext_sel, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_ctrl;
    logic [3:0] state_o;
    exp_t       obs;

    int errors = 0;
    int checks = 0;
    step_t q[$];

    mc_control_fsm #(.OPW(6), .SW(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .ext_sel(ext_sel), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs = {state_o, pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl, ext_sel, illegal};

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e = '0;
        e.st = st;
        e.ext_sel = 1'b1;
        return e;
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    task automatic push(input exp_t e, input logic rdy, input logic z);
        step_t s;
        s.e = e; s.rdy = rdy; s.z = z;
        q.push_back(s);
    endtask

    // Expected trace for one instruction; fw/mw are not-ready cycles in fetch and in the data access
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fw, input int mw);
        exp_t e;
        bit known;
        for (int i = 0; i <= fw; i++) begin
            e = blank(S_FETCH);
            e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_ctrl = 3'b010;
            e.ir_write = (i == fw); e.pc_en = (i == fw);
            push(e, i == fw, rnd());
        end
        known = op inside {R_OP, LW, SW_OP, BEQ, BNE, ADDI, ANDI, ORI, J_OP};
        e = blank(S_DECODE);
        e.alu_src_b = 2'b11; e.alu_ctrl = 3'b010; e.illegal = !known;
        push(e, rnd(), rnd());
        if (op == LW || op == SW_OP) begin
            e = blank(S_MEMADR);
            e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctrl = 3'b010;
            push(e, rnd(), rnd());
            for (int i = 0; i <= mw; i++) begin
                e = blank(op == LW ? S_MEMRD : S_MEMWR);
                e.iord = 1;
                if (op == LW) e.mem_read = 1; else e.mem_write = 1;
                push(e, i == mw, rnd());
            end
            if (op == LW) begin
                e = blank(S_MEMWB);
                e.reg_write = 1; e.mem_to_reg = 1;
                push(e, rnd(), rnd());
            end
        end else if (op == R_OP) begin
            e = blank(S_EXEC);
            e.alu_src_a = 1; e.alu_ctrl = r_alu(fn);
            push(e, rnd(), rnd());
            e = blank(S_ALUWB);
            e.reg_write = 1; e.reg_dst = 1;
            push(e, rnd(), rnd());
        end else if (op == BEQ || op == BNE) begin
            e = blank(S_BRANCH);
            e.alu_src_a = 1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01;
            e.pc_en = (op == BEQ) ? z : !z;
            push(e, rnd(), z);
        end else if (op == ADDI || op == ANDI || op == ORI) begin
            e = blank(S_IEXEC);
            e.alu_src_a = 1; e.alu_src_b = 2'b10;
            e.alu_ctrl = (op == ANDI) ? 3'b000 : (op == ORI) ? 3'b001 : 3'b010;
            e.ext_sel = (op == ADDI);
            push(e, rnd(), rnd());
            e = blank(S_IWB);
            e.reg_write = 1;
            push(e, rnd(), rnd());
        end else if (op == J_OP) begin
            e = blank(S_JUMP);
            e.pc_src = 2'b10; e.pc_en = 1;
            push(e, rnd(), rnd());
        end
    endtask

    task automatic check(input string tag, input int idx, input exp_t e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s step %0d: observed=%h expected=%h", tag, idx, obs, e);
        end
    endtask

    // Caller is just after a falling edge; each step ends at the next falling edge
    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn);
        int idx = 0;
        opcode = op; funct = fn;
        while (q.size() > 0) begin
            step_t s = q.pop_front();
            mem_ready = s.rdy; zero = s.z;
            #1;
            check(tag, idx, s.e);
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int fw, input int mw);
        q.delete();
        build(op, fn, z, fw, mw);
        run(tag, op, fn);
    endtask

    initial begin
        exp_t e;
        logic [5:0] ops [9] = '{R_OP, LW, SW_OP, BEQ, BNE, ADDI, ANDI, ORI, J_OP};
        logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        mem_ready = 1'b1;
        #1;
        check("reset_t0", 0, '0);
        @(negedge clk);
        check("reset_hold", 0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        instr("lw", LW, 6'h00, 0, 0, 0);
        instr("sw_wait2", SW_OP, 6'h00, 0, 0, 2);
        instr("beq_z1", BEQ, 6'h00, 1, 0, 0);
        instr("beq_z0", BEQ, 6'h00, 0, 0, 0);
        instr("bne_z0", BNE, 6'h00, 0, 0, 0);
        instr("bne_z1", BNE, 6'h00, 1, 1, 0);
        instr("andi", ANDI, 6'h00, 0, 0, 0);
        instr("addi", ADDI, 6'h00, 0, 0, 0);
        instr("ori", ORI, 6'h00, 0, 0, 0);
        instr("slt", R_OP, 6'b101010, 0, 0, 0);
        instr("r_bad_funct", R_OP, 6'b111000, 0, 0, 0);
        instr("j", J_OP, 6'h00, 0, 2, 0);
        instr("illegal", 6'b111111, 6'h00, 0, 0, 0);
        instr("lw_waits", LW, 6'h00, 0, 1, 2);

        // Reset while a load is stalled in its data read
        q.delete();
        build(LW, 6'h00, 0, 0, 3);
        while (q.size() > 4) void'(q.pop_back());
        run("lw_abort", LW, 6'h00);
        mem_ready = 1'b0;
        #1;
        e = blank(S_MEMRD); e.iord = 1; e.mem_read = 1;
        check("memrd_stall", 0, e);
        rst_n = 1'b0;
        #1;
        check("reset_async", 0, '0);
        @(negedge clk);
        check("reset_async_hold", 0, '0);
        rst_n = 1'b1;
        #1;
        e = blank(S_FETCH); e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_ctrl = 3'b010;
        check("post_reset_fetch", 0, e);
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            instr("rand", op, fn, rnd(), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
